// File: rtl/audio_pkg.sv
// Shared audio types and default geometry for the codec DAC path.
// The frame type is fixed at the default sample width; parameterised blocks carry frames as flat vectors.
package audio_pkg;

    localparam int DEF_SAMPLE_WIDTH = 16;
    localparam int DEF_SLOT_WIDTH   = 32;
    localparam int DEF_BCLK_DIV     = 18;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic {
        FMT_LJ  = 1'b0,
        FMT_I2S = 1'b1
    } fmt_e;

    typedef struct packed {
        logic [DEF_SAMPLE_WIDTH-1:0] left;
        logic [DEF_SAMPLE_WIDTH-1:0] right;
    } frame_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous frame FIFO with occupancy output; pop never bypasses a same-cycle push.
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_STEP = AW'(1'b1);
    localparam logic [AW:0]   CNT_STEP = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign level     = count_r;

    // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PTR_STEP;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_STEP;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_STEP;
                2'b01:   count_r <= count_r - CNT_STEP;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/i2s_stereo_streamer.sv
// Stereo DAC serialiser: derives BCLK/DACLRCK from the master clock and shifts buffered
// PCM frames out MSB-first in I2S or left-justified format, emitting silence on underrun.
module i2s_stereo_streamer
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
    parameter int BCLK_DIV     = DEF_BCLK_DIV,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          fmt_i2s,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_WIDTH-1:0]       s_left,
    input  logic [SAMPLE_WIDTH-1:0]       s_right,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          aud_bclk,
    output logic                          aud_daclrck,
    output logic                          aud_dacdat
);

    localparam int FW = 2 * SAMPLE_WIDTH;
    localparam int DW = $clog2(BCLK_DIV);
    localparam int PW = $clog2(SLOT_WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_STEP = DW'(1'b1);
    localparam logic [PW-1:0] POS_LAST = PW'(SLOT_WIDTH - 1);
    localparam logic [PW-1:0] POS_STEP = PW'(1'b1);
    localparam logic [SAMPLE_WIDTH-1:0] MSB_MASK = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    logic             run_r;
    logic [DW-1:0]    div_r;
    logic             bclk_r;
    logic             lrck_r;
    logic [PW-1:0]    pos_r;
    logic [FW-1:0]    frame_r;
    fmt_e             fmt_r;
    logic             dacdat_r;
    logic             underrun_r;

    logic [DW-1:0]    div_nxt;
    logic             bclk_nxt;
    logic             lrck_nxt;
    logic [PW-1:0]    pos_nxt;
    logic [FW-1:0]    frame_nxt;
    fmt_e             fmt_nxt;
    logic             dacdat_nxt;
    logic             start_s;
    logic             frame_start_s;
    logic [PW:0]      bit_off_s;
    logic [SAMPLE_WIDTH-1:0] sample_s;

    logic [FW-1:0]    head_s;
    logic             full_s;
    logic             empty_s;

    sample_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (s_valid),
        .pop     (frame_start_s),
        .wr_data ({s_left, s_right}),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (fifo_level)
    );

    assign s_ready     = ~full_s;
    assign start_s     = enable & ~run_r;
    assign aud_bclk    = bclk_r;
    assign aud_daclrck = lrck_r;
    assign aud_dacdat  = dacdat_r;
    assign underrun    = underrun_r;

    // Next serial state; dacdat is derived from the next state so it tracks slot/frame updates in the same edge.
    always_comb begin
        div_nxt       = div_r;
        bclk_nxt      = bclk_r;
        lrck_nxt      = lrck_r;
        pos_nxt       = pos_r;
        frame_start_s = 1'b0;
        if (!enable) begin
            div_nxt  = {DW{1'b0}};
            bclk_nxt = 1'b0;
            lrck_nxt = 1'b0;
            pos_nxt  = {PW{1'b0}};
        end else if (start_s) begin
            div_nxt       = {DW{1'b0}};
            bclk_nxt      = 1'b0;
            lrck_nxt      = 1'b0;
            pos_nxt       = {PW{1'b0}};
            frame_start_s = 1'b1;
        end else if (div_r == DIV_LAST) begin
            div_nxt  = {DW{1'b0}};
            bclk_nxt = ~bclk_r;
            if (bclk_r && (pos_r == POS_LAST)) begin
                pos_nxt       = {PW{1'b0}};
                lrck_nxt      = ~lrck_r;
                frame_start_s = lrck_r;
            end else if (bclk_r) begin
                pos_nxt = pos_r + POS_STEP;
            end else begin
                pos_nxt = pos_r;
            end
        end else begin
            div_nxt = div_r + DIV_STEP;
        end

        if (!enable) begin
            frame_nxt = {FW{1'b0}};
            fmt_nxt   = FMT_LJ;
        end else if (frame_start_s) begin
            frame_nxt = empty_s ? {FW{1'b0}} : head_s;
            fmt_nxt   = fmt_e'(fmt_i2s);
        end else begin
            frame_nxt = frame_r;
            fmt_nxt   = fmt_r;
        end

        sample_s  = lrck_nxt ? frame_nxt[SAMPLE_WIDTH-1:0] : frame_nxt[FW-1:SAMPLE_WIDTH];
        // I2S at p=0 wraps the offset to a huge value, which shifts the mask out and yields 0.
        bit_off_s  = {1'b0, pos_nxt} - {{PW{1'b0}}, (fmt_nxt == FMT_I2S)};
        dacdat_nxt = |(sample_s & (MSB_MASK >> bit_off_s));
    end

    // Serial state and registered codec pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r      <= 1'b0;
            div_r      <= {DW{1'b0}};
            bclk_r     <= 1'b0;
            lrck_r     <= 1'b0;
            pos_r      <= {PW{1'b0}};
            frame_r    <= {FW{1'b0}};
            fmt_r      <= FMT_LJ;
            dacdat_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            run_r      <= enable;
            div_r      <= div_nxt;
            bclk_r     <= bclk_nxt;
            lrck_r     <= lrck_nxt;
            pos_r      <= pos_nxt;
            frame_r    <= frame_nxt;
            fmt_r      <= fmt_nxt;
            dacdat_r   <= dacdat_nxt;
            underrun_r <= frame_start_s & empty_s;
        end
    end

endmodule

// File: tb/tb_i2s_stereo_streamer.sv
// Scoreboard bench: accepted frames are queued, each frame start pops the expected frame
// and every completed slot is compared bit-for-bit against the format-dependent pattern.
module tb_i2s_stereo_streamer;
    import audio_pkg::*;

    localparam int SW         = 16;
    localparam int SLOT       = 32;
    localparam int DIV        = 18;
    localparam int DEPTH      = 4;
    localparam int FRAME_CLKS = 2 * SLOT * 2 * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fmt_i2s;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;

    int checks   = 0;
    int failures = 0;

    i2s_stereo_streamer #(
        .SAMPLE_WIDTH (SW),
        .SLOT_WIDTH   (SLOT),
        .BCLK_DIV     (DIV),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .fmt_i2s     (fmt_i2s),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slot_exp(input logic [15:0] s, input logic i2s);
        logic [31:0] v;
        v = {s, 16'h0000};
        if (i2s) v = v >> 1;
        return v;
    endfunction

    // scoreboard / monitor state
    frame_t      sb_q[$];
    frame_t      cur;
    frame_t      pend_frame;
    logic        pend = 1'b0;
    logic        cur_fmt = 1'b0;
    logic        active = 1'b0;
    logic        slot = 1'b0;
    int          p = 0;
    logic [31:0] slot_bits = 32'h0;
    logic        en_h1 = 1'b0, en_h2 = 1'b0, fmt_h1 = 1'b0;
    logic        prev_bclk = 1'b0, prev_lrck = 1'b0, prev_dat = 1'b0;
    logic        start_ev;
    int          cyc = 0;
    int          last_rise = -1;
    int          lrck_err = 0;
    int          glitches = 0;
    int          und_seen = 0;
    int          und_exp = 0;
    int          frames_done = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                sb_q.delete();
                pend = 1'b0; active = 1'b0; p = 0; slot = 1'b0;
                en_h1 = 1'b0; en_h2 = 1'b0; last_rise = -1;
            end else begin
                if (underrun) und_seen++;
                if (!en_h1) begin
                    active = 1'b0;
                    last_rise = -1;
                end else begin
                    start_ev = !en_h2 || (prev_lrck && !aud_daclrck);
                    if (!start_ev && (aud_dacdat != prev_dat) && !(prev_bclk && !aud_bclk)) glitches++;
                    if (start_ev) begin
                        if (sb_q.size() == 0) begin
                            cur = '0;
                            und_exp++;
                            check_eq("underrun_start", 32'(underrun), 32'd1);
                        end else begin
                            cur = sb_q.pop_front();
                            check_eq("underrun_start", 32'(underrun), 32'd0);
                        end
                        cur_fmt = fmt_h1;
                        active = 1'b1; p = 0; slot = 1'b0;
                    end
                    if (active && aud_bclk && !prev_bclk) begin
                        slot_bits = {slot_bits[30:0], aud_dacdat};
                        if (aud_daclrck != slot) lrck_err++;
                        if (p == SLOT - 1) begin
                            check_eq(slot ? "slot_right" : "slot_left", slot_bits,
                                     slot_exp(slot ? cur.right : cur.left, cur_fmt));
                            if (slot) frames_done++;
                            p = 0;
                            slot = ~slot;
                        end else begin
                            p++;
                        end
                    end
                    if (aud_daclrck && !prev_lrck) begin
                        if (last_rise >= 0) check_eq("lrck_period", 32'(cyc - last_rise), 32'(FRAME_CLKS));
                        last_rise = cyc;
                    end
                end
                // a push at this edge cannot be seen by a frame start at this same edge
                if (pend) sb_q.push_back(pend_frame);
                pend = s_valid && s_ready;
                pend_frame = '{left: s_left, right: s_right};
                en_h2 = en_h1; en_h1 = enable; fmt_h1 = fmt_i2s;
            end
            prev_bclk = aud_bclk; prev_lrck = aud_daclrck; prev_dat = aud_dacdat;
        end
    end

    task automatic push_frame(input logic [15:0] l, input logic [15:0] r);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        s_valid = 1'b1; s_left = l; s_right = r;
        for (int i = 0; i < 10000 && !ok; i++) begin
            @(posedge clk);
            if (s_ready) ok = 1'b1;
        end
        if (!ok) check_eq("push_timeout", 32'd0, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_lrck(input logic v);
        int n;
        n = 0;
        while (aud_daclrck !== v && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) check_eq("wait_lrck_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_lines_low(input string tag);
        check_eq(tag, {29'd0, aud_bclk, aud_daclrck, aud_dacdat}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; fmt_i2s = 1'b0;
        s_valid = 1'b0; s_left = 16'h0000; s_right = 16'h0000;
        repeat (3) @(negedge clk);
        check_lines_low("reset_lines");
        check_eq("reset_underrun", 32'(underrun), 32'd0);
        check_eq("reset_level", 32'(fifo_level), 32'd0);
        check_eq("reset_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;

        // fill the FIFO while idle, then hold a fifth frame against a full FIFO
        push_frame(16'hA5C3, 16'h0F0F);
        push_frame(16'h1234, 16'h8001);
        push_frame(16'h7FFF, 16'hFFFF);
        push_frame(16'h0001, 16'h8000);
        check_eq("full_ready", 32'(s_ready), 32'd0);
        check_eq("full_level", 32'(fifo_level), 32'd4);
        s_valid = 1'b1; s_left = 16'hBEEF; s_right = 16'h4321;
        repeat (5) @(negedge clk);
        check_eq("full_hold_level", 32'(fifo_level), 32'd4);
        check_eq("full_hold_ready", 32'(s_ready), 32'd0);

        // left-justified run: MSB of the first left sample appears one cycle after enable
        enable = 1'b1;
        @(posedge clk); #1;
        check_eq("lj_first_msb", 32'(aud_dacdat), 32'd1);
        check_eq("lj_first_lrck", 32'(aud_daclrck), 32'd0);
        check_eq("pop_on_start", 32'(fifo_level), 32'd3);
        @(negedge clk);
        @(posedge clk); #1;
        check_eq("fifth_accepted", 32'(fifo_level), 32'd4);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (6 * FRAME_CLKS + 200) @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check_lines_low("disable_low");

        // I2S run: first BCLK rise BCLK_DIV cycles after enable, MSB at p=1
        @(negedge clk);
        fmt_i2s = 1'b1;
        push_frame(16'hA5C3, 16'h0F0F);
        push_frame(16'h1357, 16'h2468);
        enable = 1'b1;
        @(posedge clk); #1;
        check_eq("i2s_p0_zero", 32'(aud_dacdat), 32'd0);
        repeat (DIV - 1) @(posedge clk);
        #1;
        check_eq("bclk_pre_rise", 32'(aud_bclk), 32'd0);
        @(posedge clk); #1;
        check_eq("bclk_first_rise", 32'(aud_bclk), 32'd1);
        repeat (DIV) @(posedge clk);
        #1;
        check_eq("i2s_p1_msb", 32'(aud_dacdat), 32'd1);

        // drain into underrun, then queue two frames mid-frame
        repeat (3 * FRAME_CLKS + 100) @(negedge clk);
        push_frame(16'hCAFE, 16'hF00D);
        push_frame(16'h0BAD, 16'hD00D);
        wait_lrck(1'b1);
        wait_lrck(1'b0);
        wait_lrck(1'b1);
        repeat (300) @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        check_lines_low("disable_mid_right");
        check_eq("fifo_kept", 32'(fifo_level), 32'd1);
        repeat (20) @(negedge clk);
        enable = 1'b1;
        wait_lrck(1'b1);
        push_frame(16'h1111, 16'h2222);
        wait_lrck(1'b0);
        repeat (300) @(negedge clk);
        push_frame(16'h3333, 16'h4444);
        check_eq("level_before_reset", 32'(fifo_level), 32'd1);

        // aggregate checks before the asynchronous reset clears the model
        check_eq("underrun_count", 32'(und_seen), 32'(und_exp));
        check_eq("dacdat_only_on_fall", 32'(glitches), 32'd0);
        check_eq("lrck_align", 32'(lrck_err), 32'd0);
        check_eq("frames_done_min", 32'(frames_done >= 10), 32'd1);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_lines_low("async_reset_lines");
        check_eq("async_reset_underrun", 32'(underrun), 32'd0);
        check_eq("async_reset_level", 32'(fifo_level), 32'd0);
        check_eq("async_reset_ready", 32'(s_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
